dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the CPU load/store path
//  and a host port used for program/data loading and debug readback. It arbitrates

---
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Round-robin sharing of a single-port fixed-latency data memory
//               between the CPU load/store path and the host loader port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              addr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_access   = 2'd1;
    localparam logic [1:0] c_resp     = 2'd2;
    localparam logic       c_cpu      = 1'b0;
    localparam logic       c_host     = 1'b1;
    localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_misalign;
    logic [3:0]        r_cnt;
    logic              r_cpu_ready;
    logic              r_host_ready;
    logic              r_addr_err;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_host_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;

    logic              w_grant;
    logic              w_cpu_win;
    logic              w_g_we;
    logic [31:0]       w_g_addr;
    logic [DATA_W-1:0] w_g_wdata;
    logic              w_misalign;
    logic              w_unused;

    // On a tie the CPU wins only if the host was served last.
    assign w_grant    = cpu_req | host_req;
    assign w_cpu_win  = cpu_req & (~host_req | (r_last_grant == c_host));
    assign w_g_we     = w_cpu_win ? cpu_we    : host_we;
    assign w_g_addr   = w_cpu_win ? cpu_addr  : host_addr;
    assign w_g_wdata  = w_cpu_win ? cpu_wdata : host_wdata;
    assign w_misalign = (w_g_addr[1:0] != 2'b00);

    // Address bits above the word index wrap and are intentionally dropped.
    assign w_unused = ^{cpu_addr[31:ADDR_W+2], host_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_idle;
            r_owner      <= c_cpu;
            r_last_grant <= c_host;
            r_misalign   <= 1'b0;
            r_cnt        <= 4'd0;
            r_cpu_ready  <= 1'b0;
            r_host_ready <= 1'b0;
            r_addr_err   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_grant) begin
                        r_owner      <= w_cpu_win ? c_cpu : c_host;
                        r_last_grant <= w_cpu_win ? c_cpu : c_host;
                        r_misalign   <= w_misalign;
                        r_cnt        <= c_cnt_init;
                        r_mem_addr   <= w_g_addr[ADDR_W+1:2];
                        r_mem_wdata  <= w_g_wdata;
                        r_mem_we     <= w_g_we & ~w_misalign;
                        r_state      <= c_access;
                    end
                end
                c_access: begin
                    r_mem_we <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        if (r_owner == c_cpu) begin
                            r_cpu_rdata <= r_misalign ? '0 : mem_rdata;
                        end else begin
                            r_host_rdata <= r_misalign ? '0 : mem_rdata;
                        end
                        r_cpu_ready  <= (r_owner == c_cpu);
                        r_host_ready <= (r_owner == c_host);
                        r_addr_err   <= r_misalign;
                        r_state      <= c_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_resp: begin
                    r_cpu_ready  <= 1'b0;
                    r_host_ready <= 1'b0;
                    r_addr_err   <= 1'b0;
                    r_state      <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign cpu_ready  = r_cpu_ready;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_stall  = cpu_req & ~r_cpu_ready;
    assign host_ready = r_host_ready;
    assign host_rdata = r_host_rdata;
    assign addr_err   = r_addr_err;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Scoreboard bench; instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [2];
    logic        cpu_req    [2];
    logic        cpu_we     [2];
    logic [31:0] cpu_addr   [2];
    logic [31:0] cpu_wdata  [2];
    logic        cpu_ready  [2];
    logic [31:0] cpu_rdata  [2];
    logic        cpu_stall  [2];
    logic        host_req   [2];
    logic        host_we    [2];
    logic [31:0] host_addr  [2];
    logic [31:0] host_wdata [2];
    logic        host_ready [2];
    logic [31:0] host_rdata [2];
    logic        addr_err   [2];
    logic [9:0]  mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic        mem_we     [2];
    logic [31:0] mem_rdata  [2];

    logic [31:0] mem [2][1024];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        dmem_port_arbiter #(
            .ADDR_W (10),
            .DATA_W (32),
            .MEM_LAT((k == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .reset     (reset[k]),
            .cpu_req   (cpu_req[k]),
            .cpu_we    (cpu_we[k]),
            .cpu_addr  (cpu_addr[k]),
            .cpu_wdata (cpu_wdata[k]),
            .cpu_ready (cpu_ready[k]),
            .cpu_rdata (cpu_rdata[k]),
            .cpu_stall (cpu_stall[k]),
            .host_req  (host_req[k]),
            .host_we   (host_we[k]),
            .host_addr (host_addr[k]),
            .host_wdata(host_wdata[k]),
            .host_ready(host_ready[k]),
            .host_rdata(host_rdata[k]),
            .addr_err  (addr_err[k]),
            .mem_addr  (mem_addr[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_we    (mem_we[k]),
            .mem_rdata (mem_rdata[k])
        );
        assign mem_rdata[k] = mem[k][mem_addr[k]];
    end

    typedef struct {
        int          inst;
        logic        host;
        logic        chk_data;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          we_cnt [2] = '{0, 0};
    logic [9:0]  we_addr [2];
    bit          loaded = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act === req) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory model: preload pattern A5kk_aaaa, writes land while mem_we is high.
    always @(negedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 1024; a++)
                    mem[k][a] = 32'hA500_0000 | (32'(k) << 16) | 32'(a);
            mem[0][5]  = 32'hDEAD_BEEF;
            mem[1][32] = 32'hCAFE_F00D;
            loaded = 1'b1;
        end
        for (int k = 0; k < 2; k++)
            if (mem_we[k]) mem[k][mem_addr[k]] = mem_wdata[k];
    end

    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k]) begin
                we_cnt[k]++;
                we_addr[k] = mem_addr[k];
            end
            if (cpu_ready[k] || host_ready[k]) begin
                check("one_ready", 32'(cpu_ready[k] & host_ready[k]), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_inst", 32'(k), 32'(e.inst));
                    check("resp_owner", 32'(host_ready[k]), 32'(e.host));
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    check("resp_err", 32'(addr_err[k]), 32'(e.err));
                    if (e.chk_data)
                        check("resp_rdata", e.host ? host_rdata[k] : cpu_rdata[k], e.rdata);
                end
            end else if (addr_err[k]) begin
                check("stray_addr_err", 32'd1, 32'd0);
            end
        end
    end

    task automatic expect_resp(input int k, input logic host, input logic chkd,
                               input logic [31:0] d, input logic err, input int at);
        exp_t e;
        e.inst = k; e.host = host; e.chk_data = chkd; e.rdata = d; e.err = err; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic start(input int k, input logic host, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (host) begin
            host_req[k] = 1'b1; host_we[k] = we; host_addr[k] = addr; host_wdata[k] = wd;
        end else begin
            cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd;
        end
    endtask

    task automatic finish(input int k, input logic host);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = host ? host_ready[k] : cpu_ready[k];
            if (!host) check("cpu_stall", 32'(cpu_stall[k]), 32'(!got));
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (host) host_req[k] = 1'b0; else cpu_req[k] = 1'b0;
    endtask

    task automatic access(input int k, input logic host, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic chkd, input logic [31:0] d,
                          input logic err, input int lat);
        expect_resp(k, host, chkd, d, err, cyc + lat + 1);
        start(k, host, we, addr, wd);
        finish(k, host);
    endtask

    task automatic idle_check(input int k);
        check("idle_cpu_ready", 32'(cpu_ready[k]), 32'd0);
        check("idle_host_ready", 32'(host_ready[k]), 32'd0);
        check("idle_addr_err", 32'(addr_err[k]), 32'd0);
        check("idle_mem_we", 32'(mem_we[k]), 32'd0);
        check("idle_mem_addr", 32'(mem_addr[k]), 32'd0);
        check("idle_mem_wdata", mem_wdata[k], 32'd0);
        check("idle_cpu_rdata", cpu_rdata[k], 32'd0);
        check("idle_host_rdata", host_rdata[k], 32'd0);
        check("idle_cpu_stall", 32'(cpu_stall[k]), 32'd0);
    endtask

    task automatic wait_readys(input int k, input int n);
        int seen = 0;
        for (int i = 0; i < 60 && seen < n; i++) begin
            @(negedge clk);
            if (cpu_ready[k] || host_ready[k]) seen++;
        end
        if (seen < n) check("tie_timeout", 32'(seen), 32'(n));
        @(posedge clk); #1;
        cpu_req[k]  = 1'b0;
        host_req[k] = 1'b0;
    endtask

    initial begin
        int c0;
        int w0;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            host_req[k] = 1'b0; host_we[k] = 1'b0; host_addr[k] = '0; host_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);
        idle_check(0);
        idle_check(1);
        @(posedge clk); #1;

        // Both requesters held: CPU first after reset, then strict alternation.
        c0 = cyc;
        for (int i = 0; i < 6; i++)
            expect_resp(0, 1'(i % 2), 1'b1, (i % 2) ? 32'hA500_0041 : 32'hA500_0040, 1'b0,
                        c0 + 2 + 3 * i);
        start(0, 1'b0, 1'b0, 32'h100, 32'h0);
        start(0, 1'b1, 1'b0, 32'h104, 32'h0);
        wait_readys(0, 6);

        access(0, 1'b0, 1'b0, 32'h14, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);

        w0 = we_cnt[0];
        access(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1);
        check("t2_we_pulses", 32'(we_cnt[0] - w0), 32'd1);
        check("t2_we_addr", 32'(we_addr[0]), 32'd16);
        access(0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1);

        // High address bits wrap onto word 5.
        access(0, 1'b1, 1'b0, 32'h1000_0014, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);

        w0 = we_cnt[0];
        access(0, 1'b0, 1'b1, 32'h1002, 32'h55AA_55AA, 1'b1, 32'h0, 1'b1, 1);
        access(0, 1'b1, 1'b0, 32'h45, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        check("t5_no_we", 32'(we_cnt[0] - w0), 32'd0);

        // MEM_LAT=3 host read with address hold check.
        w0 = we_cnt[1];
        expect_resp(1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, cyc + 4);
        start(1, 1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check("t4_mem_addr", 32'(mem_addr[1]), 32'd32);
        end
        finish(1, 1'b1);
        check("t4_no_we", 32'(we_cnt[1] - w0), 32'd0);

        // Reset during the ACCESS phase of a host write.
        w0 = we_cnt[1];
        start(1, 1'b1, 1'b1, 32'h20, 32'h0BAD_CAFE);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset[1] = 1'b1;
        @(posedge clk); #1;
        reset[1] = 1'b0;
        host_req[1] = 1'b0;
        @(negedge clk);
        idle_check(1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_we_pulses", 32'(we_cnt[1] - w0), 32'd1);

        c0 = cyc;
        expect_resp(1, 1'b0, 1'b1, 32'h0BAD_CAFE, 1'b0, c0 + 4);
        expect_resp(1, 1'b1, 1'b1, 32'hA501_0003, 1'b0, c0 + 9);
        start(1, 1'b0, 1'b0, 32'h20, 32'h0);
        start(1, 1'b1, 1'b0, 32'hC, 32'h0);
        wait_readys(1, 2);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
`default_nettype wire
